// File: rtl/alu_seq_pkg.sv
// alu_seq shared types and constants.
// ALU_SEQ_CHAIN_EN adds a chain bit to each queued command.
package alu_seq_pkg;

  localparam int DATA_W = 8;
  localparam int SEL_W  = 4;
  localparam int DEPTH  = 4;
  localparam int PTR_W  = 2;
  localparam int CNT_W  = 3;

  localparam logic [CNT_W-1:0] FULL_CNT = 3'd4;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    CAPT,
    HOLD
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [SEL_W-1:0]  sel;
`ifdef ALU_SEQ_CHAIN_EN
    logic              chain;
`endif
  } entry_t;

endpackage

// File: rtl/alu_seq_fifo.sv
// alu_seq_fifo: 4-entry command queue.
// Head entry is shown combinationally on rdata_o.
module alu_seq_fifo
  import alu_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  entry_t           wdata_i,
  output entry_t           rdata_o,
  output logic [CNT_W-1:0] count_o
);

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign do_push = push_i && (cnt_q < FULL_CNT);
  assign do_pop  = pop_i && (cnt_q != '0);
  assign rdata_o = mem_q[rptr_q];
  assign count_o = cnt_q;

  // Pointer and occupancy next state; pointers wrap mod 4.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = wptr_q + 2'd1;
    if (do_pop)  rptr_d = rptr_q + 2'd1;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 3'd1;
      2'b01:   cnt_d = cnt_q - 3'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: cnt_q gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: queues commands, sequences an external ALU.
// ALU_SEQ_CHAIN_EN: chained commands take A from last result.
module alu_seq
  import alu_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic              in_chain,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [DATA_W-1:0] alu_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [SEL_W-1:0]  res_sel,
  output logic              busy,
  output logic [CNT_W-1:0]  count
);

  state_e            state_q, state_d;
  entry_t            wr_entry;
  entry_t            head;
  logic [CNT_W-1:0]  cnt;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] issue_a;

  logic [DATA_W-1:0] alu_a_q, alu_b_q;
  logic [SEL_W-1:0]  alu_sel_q;
  logic [DATA_W-1:0] res_data_q;
  logic [SEL_W-1:0]  res_sel_q;
  logic              res_valid_q;

  assign in_ready = (cnt < FULL_CNT);
  assign push     = in_valid && in_ready;
  assign count    = cnt;
  assign busy     = (state_q != IDLE) || (cnt != '0);

  assign wr_entry.a   = in_a;
  assign wr_entry.b   = in_b;
  assign wr_entry.sel = in_sel;

`ifdef ALU_SEQ_CHAIN_EN
  assign wr_entry.chain = in_chain;
  // res_data_q only changes on capture, so it is the last result.
  assign issue_a = head.chain ? res_data_q : head.a;
`else
  logic unused_chain;
  assign unused_chain = in_chain;
  assign issue_a      = head.a;
`endif

  alu_seq_fifo u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wr_entry),
    .rdata_o (head),
    .count_o (cnt)
  );

  // Sequencer next state; pop marks an issue edge.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cnt != '0) begin
          state_d = EXEC;
          pop     = 1'b1;
        end
      end
      EXEC: state_d = CAPT;
      CAPT: state_d = HOLD;
      HOLD: begin
        if (res_ready) begin
          if (cnt != '0) begin
            state_d = EXEC;
            pop     = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ALU operand registers, loaded only on issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_sel_q <= '0;
    end else if (pop) begin
      alu_a_q   <= issue_a;
      alu_b_q   <= head.b;
      alu_sel_q <= head.sel;
    end
  end

  // Result capture in CAPT; held until res_ready in HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data_q  <= '0;
      res_sel_q   <= '0;
      res_valid_q <= 1'b0;
    end else if (state_q == CAPT) begin
      res_data_q  <= alu_out;
      res_sel_q   <= alu_sel_q;
      res_valid_q <= 1'b1;
    end else if (state_q == HOLD && res_ready) begin
      res_valid_q <= 1'b0;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign res_data  = res_data_q;
  assign res_sel   = res_sel_q;
  assign res_valid = res_valid_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed bench for alu_seq.
// Stub ALU registers alu_a + alu_b every edge.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = '0;
  logic [7:0] in_b = '0;
  logic [3:0] in_sel = '0;
  logic       in_chain = 1'b0;
  logic [7:0] alu_a, alu_b;
  logic [3:0] alu_sel;
  logic [7:0] alu_out = '0;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] res_data;
  logic [3:0] res_sel;
  logic       busy;
  logic [2:0] count;

  int n_run  = 0;
  int n_fail = 0;

  alu_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sel    (in_sel),
    .in_chain  (in_chain),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_sel   (res_sel),
    .busy      (busy),
    .count     (count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) alu_out <= alu_a + alu_b;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] sel, input logic ch);
    in_a     = a;
    in_b     = b;
    in_sel   = sel;
    in_chain = ch;
    in_valid = 1'b1;
  endtask

  task automatic wait_result(input string tag,
                             input logic [7:0] exp_d,
                             input logic [3:0] exp_s);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (res_valid) seen = 1;
    end
    if (!seen) begin
      check({tag, "_timeout"}, 0, 1);
    end else begin
      check({tag, "_data"}, res_data, exp_d);
      check({tag, "_sel"}, res_sel, exp_s);
    end
  endtask

  logic [2:0] full_cnt [5];
  logic [7:0] chain_exp;
  bit         late_valid;

  initial begin
    full_cnt[0] = 3'd1;
    full_cnt[1] = 3'd1;
    full_cnt[2] = 3'd2;
    full_cnt[3] = 3'd3;
    full_cnt[4] = 3'd4;
`ifdef ALU_SEQ_CHAIN_EN
    chain_exp = 8'd10;
`else
    chain_exp = 8'd4;
`endif

    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_count", count, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_res_data", res_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    offer(8'd5, 8'd2, 4'd0, 1'b0);
    tick();
    in_valid = 1'b0;
    check("single_count", count, 1);
    check("single_busy", busy, 1);
    tick();
    check("single_v1", res_valid, 0);
    check("single_alu_a", alu_a, 5);
    check("single_alu_b", alu_b, 2);
    tick();
    check("single_v2", res_valid, 0);
    tick();
    check("single_v3", res_valid, 1);
    check("single_data", res_data, 7);
    check("single_sel", res_sel, 0);

    offer(8'd10, 8'd20, 4'd3, 1'b0);
    tick();
    in_valid = 1'b0;
    check("bp_count", count, 1);
    for (int i = 0; i < 9; i++) begin
      tick();
      check("bp_valid", res_valid, 1);
      check("bp_data", res_data, 7);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("bp_ack_valid", res_valid, 0);
    check("bp_issue_a", alu_a, 10);
    check("bp_issue_count", count, 0);
    tick();
    check("bp_next_v1", res_valid, 0);
    tick();
    check("bp_next_v2", res_valid, 1);
    check("bp_next_data", res_data, 30);
    check("bp_next_sel", res_sel, 3);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("bp_done_valid", res_valid, 0);
    check("bp_done_busy", busy, 0);

    for (int k = 1; k <= 5; k++) begin
      offer(8'(k), 8'(k), 4'(k), 1'b0);
      tick();
      check("full_count", count, full_cnt[k-1]);
    end
    check("full_in_ready", in_ready, 0);
    offer(8'd6, 8'd6, 4'd6, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("full_held_count", count, 4);
      check("full_held_ready", in_ready, 0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("full_pop_count", count, 3);
    tick();
    in_valid = 1'b0;
    check("full_push6_count", count, 4);
    res_ready = 1'b1;
    for (int k = 2; k <= 6; k++) begin
      wait_result("full_drain", 8'(2 * k), 4'(k));
    end
    tick();
    check("full_idle_busy", busy, 0);

    offer(8'd5, 8'd2, 4'd0, 1'b0);
    tick();
    offer(8'd1, 8'd3, 4'd1, 1'b1);
    tick();
    in_valid = 1'b0;
    wait_result("chain_first", 8'd7, 4'd0);
    wait_result("chain_second", chain_exp, 4'd1);
    tick();
    res_ready = 1'b0;
    check("chain_idle_busy", busy, 0);

    for (int k = 1; k <= 4; k++) begin
      offer(8'(k), 8'(k), 4'(k), 1'b0);
      tick();
    end
    in_valid = 1'b0;
    check("mid_hold_count", count, 3);
    check("mid_hold_valid", res_valid, 1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("mid_exec_count", count, 2);
    check("mid_exec_alu_a", alu_a, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", res_valid, 0);
    check("mid_rst_count", count, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", in_ready, 1);
    check("mid_rst_alu_a", alu_a, 0);
    check("mid_rst_alu_sel", alu_sel, 0);
    check("mid_rst_data", res_data, 0);
    check("mid_rst_sel", res_sel, 0);
    @(negedge clk);
    rst_n = 1'b1;
    late_valid = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (res_valid) late_valid = 1;
    end
    check("post_rst_no_valid", late_valid, 0);
    check("post_rst_count", count, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
